seq_frame_tx: RTL
=================

// Module: seq_frame_tx
// PURPOSE
//  Serial frame transmitter that feeds the 1101 Moore sequence detector.
//  Takes a parallel word over a valid/ready handshake and drives one serial line.
//  Each frame is SYNC_PAT (MSB first), then DATA_W payload bits (MSB first), then GAP_CYCLES idle zeros.
//  Sits upstream of the detector's single-bit input; the line idles low.
// PARAMETERS
//  DATA_W      8        payload bits per frame; >= 1
//  SYNC_W      4        sync header length; >= 1
//  SYNC_PAT    4'b1101  sync header sent MSB first; width SYNC_W
//  GAP_CYCLES  2        forced-low cycles after payload; >= 0
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  in_valid    in   1        in_data is valid
//  in_data     in   DATA_W   payload word; bit DATA_W-1 is sent first
//  in_ready    out  1        transmitter can accept a word (high only in IDLE)
//  outp        out  1        serial line, registered
//  busy        out  1        high in SYNC, DATA and GAP
//  frame_done  out  1        one-cycle pulse after the last payload bit
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE, outp=0, busy=0, frame_done=0, in_ready=1.
//   Any frame in flight is dropped and not resumed.
//  Handshake: transfer occurs on a rising edge when in_valid & in_ready.
//   in_ready = (state==IDLE), decoded from state with no combinational path from in_valid.
//   in_data is sampled only on the transfer edge.
//  FSM states: IDLE, SYNC, DATA, GAP.
//   IDLE -> SYNC on transfer. At that edge outp<=SYNC_PAT[SYNC_W-1] and the shift register loads {SYNC_PAT, in_data}.
//   SYNC: holds SYNC_W cycles, shifting one bit per cycle, then goes to DATA.
//   DATA: holds DATA_W cycles, then goes to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES==0).
//   GAP: outp=0 for GAP_CYCLES cycles, then goes to IDLE.
//  Latency: first sync bit is on outp in the cycle after the transfer edge.
//   Frame length is SYNC_W+DATA_W+GAP_CYCLES cycles, from the transfer edge to in_ready re-asserting.
//  frame_done: high for exactly one cycle, the cycle after the last payload bit.
//   That is the first GAP cycle, or the first IDLE cycle when GAP_CYCLES==0.
//  outp is 0 in IDLE and GAP; never X after reset.
//  Back-to-back frames:
//   GAP_CYCLES==0: a transfer in the frame_done/IDLE cycle gives one cycle of 0, then the next sync.
//   Otherwise frames are separated by GAP_CYCLES+1 low cycles (GAP plus the IDLE accept cycle).
//  in_valid held high while busy has no effect; there is no queuing.
//  Bit counter width: $clog2(max(SYNC_W+DATA_W, GAP_CYCLES)+1). It counts down and reloads at each state entry.
//   No wrap-around is reachable.
//  The payload may contain 1101; resolving false detections is the receiver's concern, not this block's.
// STRUCTURE
//  Shared include seq_defs.vh: state encodings (IDLE=2'd0, SYNC=2'd1, DATA=2'd2, GAP=2'd3) and default SYNC_PAT 4'b1101.
//   The detector side uses the same constant.
//  One sub-module: piso_shift.
//   Parameterised width SYNC_W+DATA_W; load, shift enable, MSB out.
//  The FSM, counter and output register stay in seq_frame_tx.
// TESTING
//  1 Reset: rst_n low mid-DATA -> outp, busy, frame_done all 0 immediately; in_ready=1; no further frame bits.
//  2 Single frame: in_data=8'hA5, defaults -> outp = 1,1,0,1, 1,0,1,0,0,1,0,1, then 0,0.
//    frame_done pulses on the first 0 of the gap; in_ready rises 14 cycles after the transfer edge.
//  3 Receiver loop: connect outp to the 1101 detector, in_data=8'h00 -> detector asserts exactly once,
//    in the cycle after the last sync bit.
//  4 Backpressure: in_valid held high across 3 words -> each word sent once, in order.
//    Each new sync starts GAP_CYCLES+1 cycles after the previous payload ends.
//  5 GAP_CYCLES=0, DATA_W=1, in_data=1'b1 -> 1,1,0,1,1, then 0 (IDLE), then next frame.
//    frame_done coincides with in_ready.
//  6 in_valid pulsed while busy -> ignored; outp sequence unchanged and in_ready stays 0 until frame end.

Source files
------------

// File: rtl/seq_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding,
// the default sync header (also used by the downstream 1101 detector) and
// a small helper for sizing the bit counter.
package seq_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_frame_tx_piso.sv
// Parallel-in / serial-out shift register holding {sync, payload}.
// next_msb is the bit that becomes the MSB after the pending shift, which
// lets the transmitter's output register present each bit in the cycle
// right after the shift that exposes it.
module seq_frame_tx_piso #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         next_msb
);

  logic [W-1:0] data_q;

  // Load has priority over shift; shift moves bits toward the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      data_q <= {data_q[W-2:0], 1'b0};
    end
  end

  assign next_msb = data_q[W-2];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a parallel word and sends SYNC_PAT,
// then the payload (both MSB first), then GAP_CYCLES forced-low cycles.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is decoded purely from state (high only in IDLE), so there is no
// combinational path from in_valid to in_ready; in_data is sampled only on
// that transfer edge, and in_valid while busy is ignored (no queuing).
module seq_frame_tx
  import seq_frame_tx_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEFAULT,
  parameter int                GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              outp,
  output logic              busy,
  output logic              frame_done
);

  localparam int SR_W  = SYNC_W + DATA_W;
  localparam int CNT_W = $clog2(max_int(SR_W, GAP_CYCLES) + 1);

  // Counter reload values: each state counts down to zero from its length-1.
  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outp_d;
  logic             done_d;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_next;

  seq_frame_tx_piso #(
    .W (SR_W)
  ) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data ({SYNC_PAT, in_data}),
    .next_msb  (sr_next)
  );

  // State, counter and the registered serial output / done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      outp       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outp       <= outp_d;
      frame_done <= done_d;
    end
  end

  // Next-state, counter reload and next output bit for each frame phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    outp_d   = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LOAD;
          sr_load = 1'b1;
          outp_d  = SYNC_PAT[SYNC_W-1];
        end
      end
      ST_SYNC: begin
        sr_shift = 1'b1;
        outp_d   = sr_next;
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        sr_shift = 1'b1;
        if (cnt_q == '0) begin
          // Last payload bit is on the line now; flag done for next cycle.
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          outp_d = sr_next;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

endmodule
